// File: rtl/ysyx_22050058_pipectrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding,
// stall-vector geometry, hold/release levels and performance-counter width.
// Optional feature macro used by the controller: YSYX_22050058_PERF_EN.
package ysyx_22050058_pipectrl_pkg;

   localparam int unsigned InstAdderBus = 64;
   localparam int unsigned StallBus     = 5;
   localparam int unsigned PerfCntW     = 64;

   // Stall-vector bit positions (one per held register)
   localparam int unsigned StallPc    = 0;
   localparam int unsigned StallIfId  = 1;
   localparam int unsigned StallIdEx  = 2;
   localparam int unsigned StallExMem = 3;
   localparam int unsigned StallMemWb = 4;

   localparam logic StallEnable  = 1'b1;
   localparam logic StallDisable = 1'b0;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      REDIR_PEND = 2'd1,
      HALT       = 2'd2
   } pipe_state_e;

   // Hold every register from the PC up to and including index k.
   function automatic logic [StallBus-1:0] stall_upto(input int unsigned k);
      logic [StallBus-1:0] m;
      for (int unsigned i = 0; i < StallBus; i++) begin
         m[i] = (i <= k) ? StallEnable : StallDisable;
      end
      return m;
   endfunction

endpackage

// File: rtl/ysyx_22050058_perfcnt.sv
// Performance counters for the pipeline controller.
// Ports:
//   clk, rst      core clock, synchronous active-high reset
//   count_en_i    pipeline not frozen (counters advance only when set)
//   stall_i       PC hold active this cycle
//   redirect_i    a redirect was handed to fetch this cycle
//   cycle_o / stall_o / redirect_o   64-bit free-wrapping counts
module ysyx_22050058_perfcnt
   import ysyx_22050058_pipectrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                count_en_i,
   input  logic                stall_i,
   input  logic                redirect_i,
   output logic [PerfCntW-1:0] cycle_o,
   output logic [PerfCntW-1:0] stall_o,
   output logic [PerfCntW-1:0] redirect_o
);

   logic [PerfCntW-1:0] cycle_q, cycle_d;
   logic [PerfCntW-1:0] stall_q, stall_d;
   logic [PerfCntW-1:0] redir_q, redir_d;

   always_comb begin
      cycle_d = cycle_q;
      stall_d = stall_q;
      redir_d = redir_q;
      if (count_en_i) begin
         cycle_d = cycle_q + 1'b1;
         if (stall_i)    stall_d = stall_q + 1'b1;
         if (redirect_i) redir_d = redir_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_q <= '0;
         stall_q <= '0;
         redir_q <= '0;
      end else begin
         cycle_q <= cycle_d;
         stall_q <= stall_d;
         redir_q <= redir_d;
      end
   end

   assign cycle_o    = cycle_q;
   assign stall_o    = stall_q;
   assign redirect_o = redir_q;

endmodule

// File: rtl/ysyx_22050058_pipectrl.sv
// Pipeline controller for the 5-stage RV64 core.
// Merges per-stage stall requests into a register hold vector, flushes the
// wrong-path registers on a taken EX branch/jump, redirects fetch (holding the
// target while fetch is busy) and freezes the pipeline once a stop retires.
// Ports:
//   clk, rst                      core clock, synchronous active-high reset
//   *_stallreq_i                  per-stage "cannot advance" requests
//   ex_isjump_i, ex_jumpaddr_i    taken branch/jump and its target from EX
//   if_redirect_ready_i           fetch can accept a redirect this cycle
//   wb_instvalid_i, wb_dpicstop_i retiring instruction valid / is a stop
//   stall_o[4:0]                  hold: PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//   flush_o[1:0]                  clear IF/ID, clear ID/EX
//   redirect_valid_o/addr_o       fetch redirect
//   halted_o                      pipeline frozen
//   perf_*_o                      counters; real only with YSYX_22050058_PERF_EN,
//                                 otherwise tied to zero
module ysyx_22050058_pipectrl
   import ysyx_22050058_pipectrl_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_stallreq_i,
   input  logic                    id_stallreq_i,
   input  logic                    ex_stallreq_i,
   input  logic                    mem_stallreq_i,
   input  logic                    ex_isjump_i,
   input  logic [InstAdderBus-1:0] ex_jumpaddr_i,
   input  logic                    if_redirect_ready_i,
   input  logic                    wb_instvalid_i,
   input  logic                    wb_dpicstop_i,
   output logic [StallBus-1:0]     stall_o,
   output logic [1:0]              flush_o,
   output logic                    redirect_valid_o,
   output logic [InstAdderBus-1:0] redirect_addr_o,
   output logic                    halted_o,
   output logic [PerfCntW-1:0]     perf_cycle_o,
   output logic [PerfCntW-1:0]     perf_stall_o,
   output logic [PerfCntW-1:0]     perf_redirect_o
);

   pipe_state_e             state_q, state_d;
   logic [InstAdderBus-1:0] addr_q, addr_d;
   logic [StallBus-1:0]     stall_merge;
   logic                    stop_seen;
   logic                    jump_ok;

   assign stop_seen = wb_instvalid_i & wb_dpicstop_i;
   // A jump is only acted on once EX actually advances; otherwise it repeats.
   assign jump_ok   = ex_isjump_i & ~ex_stallreq_i & ~mem_stallreq_i;

   // Most downstream requester wins; the register just above the held range
   // receives a bubble by the stage-register rule.
   always_comb begin
      stall_merge = '0;
      if (mem_stallreq_i)     stall_merge = stall_upto(StallMemWb);
      else if (ex_stallreq_i) stall_merge = stall_upto(StallExMem);
      else if (id_stallreq_i) stall_merge = stall_upto(StallIdEx);
      else if (if_stallreq_i) stall_merge = stall_upto(StallIfId);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         RUN: begin
            if (stop_seen) begin
               state_d = HALT;
               addr_d  = '0;
            end else if (jump_ok && !if_redirect_ready_i) begin
               state_d = REDIR_PEND;
               addr_d  = ex_jumpaddr_i;
            end
         end
         REDIR_PEND: begin
            if (stop_seen) begin
               state_d = HALT;
               addr_d  = '0;
            end else if (if_redirect_ready_i) begin
               state_d = RUN;
               addr_d  = '0;
            end
         end
         HALT:    state_d = HALT;
         default: begin
            state_d = RUN;
            addr_d  = '0;
         end
      endcase
   end

   // Output logic; a same-cycle stop suppresses any flush/redirect.
   always_comb begin
      stall_o          = '0;
      flush_o          = '0;
      redirect_valid_o = 1'b0;
      redirect_addr_o  = '0;
      case (state_q)
         RUN: begin
            stall_o = stall_merge;
            if (jump_ok && !stop_seen) begin
               flush_o = 2'b11;
               if (if_redirect_ready_i) begin
                  redirect_valid_o = 1'b1;
                  redirect_addr_o  = ex_jumpaddr_i;
               end
            end
         end
         REDIR_PEND: begin
            stall_o = stall_merge;
            if (!stop_seen) begin
               flush_o[0]       = 1'b1;
               redirect_valid_o = 1'b1;
               redirect_addr_o  = addr_q;
            end
         end
         HALT:    stall_o = {StallBus{StallEnable}};
         default: stall_o = '0;
      endcase
   end

   assign halted_o = (state_q == HALT);

`ifdef YSYX_22050058_PERF_EN
   ysyx_22050058_perfcnt u_perfcnt (
      .clk        (clk),
      .rst        (rst),
      .count_en_i (state_q != HALT),
      .stall_i    (stall_o[StallPc]),
      .redirect_i (redirect_valid_o & if_redirect_ready_i),
      .cycle_o    (perf_cycle_o),
      .stall_o    (perf_stall_o),
      .redirect_o (perf_redirect_o)
   );
`else
   assign perf_cycle_o    = '0;
   assign perf_stall_o    = '0;
   assign perf_redirect_o = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050058_pipectrl.sv
module tb_ysyx_22050058_pipectrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, id_req, ex_req, mem_req;
   logic        isjump;
   logic [63:0] jaddr;
   logic        rdy;
   logic        ivalid, istop;
   logic [4:0]  stall;
   logic [1:0]  flush;
   logic        rvalid;
   logic [63:0] raddr;
   logic        halted;
   logic [63:0] pcyc, pstl, prdr;

`ifdef YSYX_22050058_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   always #5 clk = ~clk;

   ysyx_22050058_pipectrl dut (
      .clk                 (clk),
      .rst                 (rst),
      .if_stallreq_i       (if_req),
      .id_stallreq_i       (id_req),
      .ex_stallreq_i       (ex_req),
      .mem_stallreq_i      (mem_req),
      .ex_isjump_i         (isjump),
      .ex_jumpaddr_i       (jaddr),
      .if_redirect_ready_i (rdy),
      .wb_instvalid_i      (ivalid),
      .wb_dpicstop_i       (istop),
      .stall_o             (stall),
      .flush_o             (flush),
      .redirect_valid_o    (rvalid),
      .redirect_addr_o     (raddr),
      .halted_o            (halted),
      .perf_cycle_o        (pcyc),
      .perf_stall_o        (pstl),
      .perf_redirect_o     (prdr)
   );

   typedef struct {
      logic [4:0]  stall;
      logic [1:0]  flush;
      logic        rv;
      logic [63:0] ra;
      logic        halt;
      logic        pchk;
      logic [63:0] pc, ps, pr;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // perf expectation attached to the next vector when p_chk is set
   logic        p_chk = 1'b0;
   logic [63:0] p_c, p_s, p_r;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One cycle: drive inputs, queue the expected outputs, compare at negedge.
   task automatic run(input logic r, input logic [3:0] req, input logic j,
                      input logic [63:0] ja, input logic rd, input logic stp,
                      input logic [4:0] es, input logic [1:0] ef, input logic erv,
                      input logic [63:0] era, input logic eh);
      exp_t e, g;
      @(posedge clk);
      #1;
      rst = r;
      {mem_req, ex_req, id_req, if_req} = req;
      isjump = j; jaddr = ja; rdy = rd;
      ivalid = stp; istop = stp;
      e.stall = es; e.flush = ef; e.rv = erv; e.ra = era; e.halt = eh;
      e.pchk = p_chk; e.pc = p_c; e.ps = p_s; e.pr = p_r;
      sb.push_back(e);
      @(negedge clk);
      g = sb.pop_front();
      check("stall",    64'(stall),  64'(g.stall));
      check("flush",    64'(flush),  64'(g.flush));
      check("rvalid",   64'(rvalid), 64'(g.rv));
      check("raddr",    raddr,       g.ra);
      check("halted",   64'(halted), 64'(g.halt));
      if (g.pchk) begin
         check("perf_cycle", pcyc, g.pc);
         check("perf_stall", pstl, g.ps);
         check("perf_redir", prdr, g.pr);
      end
   endtask

   task automatic set_perf(input logic [63:0] c, input logic [63:0] s, input logic [63:0] r);
      p_chk = 1'b1;
      p_c = PERF ? c : 64'd0;
      p_s = PERF ? s : 64'd0;
      p_r = PERF ? r : 64'd0;
   endtask

   localparam logic [63:0] A1 = 64'h0000_0000_8000_0100;
   localparam logic [63:0] A2 = 64'h0000_0000_8000_0200;
   localparam logic [63:0] A3 = 64'h0000_0000_8000_0300;
   localparam logic [63:0] AX = 64'h0000_0000_dead_beef;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      {mem_req, ex_req, id_req, if_req} = '0;
      isjump = 1'b0; jaddr = '0; rdy = 1'b0; ivalid = 1'b0; istop = 1'b0;
      repeat (2) @(posedge clk);

      // reset state
      set_perf(0, 0, 0);
      run(1, 4'b0000, 0, 0, 0, 0, 5'b00000, 2'b00, 0, 0, 0);
      p_chk = 1'b0;

      // stall merge: req = {mem, ex, id, if}
      run(0, 4'b0000, 0, 0, 1, 0, 5'b00000, 2'b00, 0, 0, 0);
      run(0, 4'b0001, 0, 0, 1, 0, 5'b00011, 2'b00, 0, 0, 0);
      run(0, 4'b0010, 0, 0, 1, 0, 5'b00111, 2'b00, 0, 0, 0);
      run(0, 4'b0100, 0, 0, 1, 0, 5'b01111, 2'b00, 0, 0, 0);
      run(0, 4'b1010, 0, 0, 1, 0, 5'b11111, 2'b00, 0, 0, 0);
      run(0, 4'b0011, 0, 0, 1, 0, 5'b00111, 2'b00, 0, 0, 0);

      // ready jump: same-cycle flush and redirect, then quiet
      run(0, 4'b0000, 1, A1, 1, 0, 5'b00000, 2'b11, 1, A1, 0);
      run(0, 4'b0000, 0, 0,  1, 0, 5'b00000, 2'b00, 0, 0,  0);
      // jump while EX or MEM stalled is ignored
      run(0, 4'b0100, 1, A1, 1, 0, 5'b01111, 2'b00, 0, 0,  0);
      run(0, 4'b1000, 1, A1, 1, 0, 5'b11111, 2'b00, 0, 0,  0);

      // not-ready jump: held four cycles, wrong-path jump ignored
      run(0, 4'b0000, 1, A2, 0, 0, 5'b00000, 2'b11, 0, 0,  0);
      run(0, 4'b0000, 1, AX, 0, 0, 5'b00000, 2'b01, 1, A2, 0);
      run(0, 4'b0010, 0, 0,  0, 0, 5'b00111, 2'b01, 1, A2, 0);
      run(0, 4'b0000, 0, 0,  0, 0, 5'b00000, 2'b01, 1, A2, 0);
      run(0, 4'b0000, 0, 0,  1, 0, 5'b00000, 2'b01, 1, A2, 0);
      run(0, 4'b0000, 0, 0,  1, 0, 5'b00000, 2'b00, 0, 0,  0);

      // perf: 10 counted cycles, 3 with ID stall, 2 accepted redirects
      run(1, 4'b0000, 0, 0,  1, 0, 5'b00000, 2'b00, 0, 0,  0);
      run(0, 4'b0010, 0, 0,  1, 0, 5'b00111, 2'b00, 0, 0,  0);
      run(0, 4'b0000, 1, A1, 1, 0, 5'b00000, 2'b11, 1, A1, 0);
      run(0, 4'b0010, 0, 0,  1, 0, 5'b00111, 2'b00, 0, 0,  0);
      run(0, 4'b0000, 0, 0,  1, 0, 5'b00000, 2'b00, 0, 0,  0);
      run(0, 4'b0000, 0, 0,  1, 0, 5'b00000, 2'b00, 0, 0,  0);
      run(0, 4'b0010, 0, 0,  1, 0, 5'b00111, 2'b00, 0, 0,  0);
      run(0, 4'b0000, 1, A2, 1, 0, 5'b00000, 2'b11, 1, A2, 0);
      run(0, 4'b0000, 0, 0,  1, 0, 5'b00000, 2'b00, 0, 0,  0);
      run(0, 4'b0000, 0, 0,  1, 0, 5'b00000, 2'b00, 0, 0,  0);
      run(0, 4'b0000, 0, 0,  0, 0, 5'b00000, 2'b00, 0, 0,  0);
      set_perf(10, 3, 2);
      run(0, 4'b0000, 0, 0,  0, 0, 5'b00000, 2'b00, 0, 0,  0);
      p_chk = 1'b0;

      // stop retires with a ready jump: halt wins, then frozen
      run(0, 4'b0000, 1, A3, 1, 1, 5'b00000, 2'b00, 0, 0,  0);
      set_perf(12, 3, 2);
      run(0, 4'b0000, 0, 0,  1, 0, 5'b11111, 2'b00, 0, 0,  1);
      run(0, 4'b0010, 1, A3, 1, 0, 5'b11111, 2'b00, 0, 0,  1);
      run(0, 4'b0000, 0, 0,  0, 0, 5'b11111, 2'b00, 0, 0,  1);
      p_chk = 1'b0;

      // reset out of HALT
      run(1, 4'b0000, 0, 0,  1, 0, 5'b11111, 2'b00, 0, 0,  1);
      set_perf(0, 0, 0);
      run(0, 4'b0000, 0, 0,  1, 0, 5'b00000, 2'b00, 0, 0,  0);
      p_chk = 1'b0;

      // reset mid-REDIR_PEND clears the pending target
      run(0, 4'b0000, 1, A2, 0, 0, 5'b00000, 2'b11, 0, 0,  0);
      run(1, 4'b0000, 0, 0,  0, 0, 5'b00000, 2'b01, 1, A2, 0);
      run(0, 4'b0000, 0, 0,  1, 0, 5'b00000, 2'b00, 0, 0,  0);

      // stop while pending: redirect dropped, halt next cycle
      run(0, 4'b0000, 1, A1, 0, 0, 5'b00000, 2'b11, 0, 0,  0);
      run(0, 4'b0000, 0, 0,  1, 1, 5'b00000, 2'b00, 0, 0,  0);
      run(0, 4'b0000, 0, 0,  1, 0, 5'b11111, 2'b00, 0, 0,  1);

      if (sb.size() != 0) check("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
